// File: rtl/sub_pkg.sv
// Shared types for the sliced subtract scheduler: slice width, FSM states, requester id.
package sub_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef logic req_id_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/sub_slice4.sv
// 4-bit ripple subtractor slice (a - b - bin) built from full-subtract stages.
// Purely combinational; no handshake.
module sub_slice4
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] diff,
  output logic               bout
);
  logic [SLICE_W:0] bc;

  always_comb begin
    bc    = '0;
    diff  = '0;
    bc[0] = bin;
    for (int i = 0; i < SLICE_W; i++) begin
      diff[i]  = a[i] ^ b[i] ^ bc[i];
      bc[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc[i]);
    end
    bout = bc[SLICE_W];
  end
endmodule

// File: rtl/sub_slice_sched.sv
// Round-robin share of one 4-bit subtract slice between two requesters; result after WIDTH/4+1 cycles.
// Ready only in IDLE; response held until rsp_ready. Optional borrow-in ports: SUB_SLICE_SCHED_BORROW_IN_EN.
module sub_slice_sched
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
  input  logic             req0_bin,
  input  logic             req1_bin,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_diff,
  output logic             rsp_borrow
);
  localparam int NSLICE = nslice(WIDTH);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_r, b_r, diff_r;
  logic              borrow_r;
  req_id_t           id_r, last;
  logic [IDXW-1:0]   idx;

  req_id_t           gnt;
  logic              hs;
  logic              last_slice;
  logic              bin0, bin1;
  logic [SLICE_W-1:0] a_nib, b_nib, s_diff;
  logic              s_bout;

`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
  assign bin0 = req0_bin;
  assign bin1 = req1_bin;
`else
  assign bin0 = 1'b0;
  assign bin1 = 1'b0;
`endif

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) gnt = ~last;
    else if (req1_valid)          gnt = 1'b1;
  end

  assign req0_ready = !rst && (state == IDLE) && req0_valid && (gnt == 1'b0);
  assign req1_ready = !rst && (state == IDLE) && req1_valid && (gnt == 1'b1);
  assign hs         = req0_ready || req1_ready;
  assign last_slice = (idx == IDXW'(NSLICE - 1));

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_r[i*SLICE_W +: SLICE_W];
        b_nib = b_r[i*SLICE_W +: SLICE_W];
      end
    end
  end

  sub_slice4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .bin  (borrow_r),
    .diff (s_diff),
    .bout (s_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (last_slice) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      id_r     <= 1'b0;
      last     <= 1'b1;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            a_r      <= gnt ? req1_a : req0_a;
            b_r      <= gnt ? req1_b : req0_b;
            borrow_r <= gnt ? bin1 : bin0;
            id_r     <= gnt;
            last     <= gnt;
            idx      <= '0;
          end
        end
        EXEC: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) diff_r[i*SLICE_W +: SLICE_W] <= s_diff;
          end
          borrow_r <= s_bout;
          idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = (state == DONE);
  assign rsp_id     = id_r;
  assign rsp_diff   = diff_r;
  assign rsp_borrow = borrow_r;
endmodule

// File: tb/tb_sub_slice_sched.sv
// Randomized bench for sub_slice_sched against a cycle-level reference of the request/response protocol.
module tb_sub_slice_sched;
  localparam int W  = 16;
  localparam int NS = W / 4;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
  logic         req0_bin, req1_bin;
`endif
  logic         rsp_valid, rsp_ready, rsp_id, rsp_borrow;
  logic [W-1:0] rsp_diff;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_slice_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
    .req0_bin   (req0_bin),
    .req1_bin   (req1_bin),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_borrow (rsp_borrow)
  );

  // Pending requests per requester.
  logic [W-1:0] qa0[$], qb0[$], qa1[$], qb1[$];
  bit           qn0[$], qn1[$];
  int           g_log[$];

  // Reference model: 0 idle, 1 computing, 2 response pending.
  int           m_state, m_cnt, m_last, m_done_cnt, m_id;
  logic [W-1:0] m_diff;
  bit           m_bor;
  bit           pres0, pres1;

  task automatic push_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input bit bin);
    if (id == 0) begin qa0.push_back(a); qb0.push_back(b); qn0.push_back(bin); end
    else         begin qa1.push_back(a); qb1.push_back(b); qn1.push_back(bin); end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(3))
      0:       return '0;
      1:       return W'(MASK);
      default: return W'($urandom);
    endcase
  endfunction

  function automatic bit rnd_bin();
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
    return bit'($urandom_range(1));
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_idle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
    req0_bin = 1'b0; req1_bin = 1'b0;
`endif
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_last = 1; m_done_cnt = 0; m_id = 0;
    m_diff = '0; m_bor = 1'b0; pres0 = 1'b0; pres1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b0; drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    qa0.delete(); qb0.delete(); qn0.delete(); qa1.delete(); qb1.delete(); qn1.delete();
  endtask

  // rr_mode: 0 always ready, 1 random, 2 hold rsp_ready low for 3 DONE cycles.
  task automatic run_traffic(input int rr_mode, input int gap_pct, input int budget);
    bit done = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      int exp_g;
      bit e0, e1;
      longint ea, eb, en;
      if (qa0.size() == 0 && qa1.size() == 0 && m_state == 0) begin done = 1'b1; break; end
      @(negedge clk);
      if (!pres0 && qa0.size() > 0 && int'($urandom_range(99)) >= gap_pct) pres0 = 1'b1;
      if (!pres1 && qa1.size() > 0 && int'($urandom_range(99)) >= gap_pct) pres1 = 1'b1;
      req0_valid = pres0;
      req0_a = pres0 ? qa0[0] : W'($urandom);
      req0_b = pres0 ? qb0[0] : W'($urandom);
      req1_valid = pres1;
      req1_a = pres1 ? qa1[0] : W'($urandom);
      req1_b = pres1 ? qb1[0] : W'($urandom);
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
      req0_bin = pres0 ? qn0[0] : 1'($urandom);
      req1_bin = pres1 ? qn1[0] : 1'($urandom);
`endif
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(1));
        default: rsp_ready = (m_state == 2 && m_done_cnt >= 3);
      endcase
      #1;
      if (pres0 && pres1) exp_g = (m_last == 0) ? 1 : 0;
      else                exp_g = pres1 ? 1 : 0;
      e0 = (m_state == 0) && pres0 && exp_g == 0;
      e1 = (m_state == 0) && pres1 && exp_g == 1;
      n_cmp++;
      if (req0_ready !== e0) begin n_bad++; $display("FAIL req0_ready cyc=%0d: got %b want %b", cyc, req0_ready, e0); end
      n_cmp++;
      if (req1_ready !== e1) begin n_bad++; $display("FAIL req1_ready cyc=%0d: got %b want %b", cyc, req1_ready, e1); end
      n_cmp++;
      if (rsp_valid !== (m_state == 2)) begin n_bad++; $display("FAIL rsp_valid cyc=%0d: got %b want %b", cyc, rsp_valid, m_state == 2); end
      if (m_state == 2) begin
        n_cmp++;
        if (rsp_id !== 1'(m_id)) begin n_bad++; $display("FAIL rsp_id: got %0d want %0d", rsp_id, m_id); end
        n_cmp++;
        if (rsp_diff !== m_diff) begin n_bad++; $display("FAIL rsp_diff: got %h want %h", rsp_diff, m_diff); end
        n_cmp++;
        if (rsp_borrow !== m_bor) begin n_bad++; $display("FAIL rsp_borrow: got %b want %b", rsp_borrow, m_bor); end
      end
      case (m_state)
        0: if (e0 || e1) begin
          if (exp_g == 0) begin ea = qa0.pop_front(); eb = qb0.pop_front(); en = qn0.pop_front(); pres0 = 1'b0; end
          else            begin ea = qa1.pop_front(); eb = qb1.pop_front(); en = qn1.pop_front(); pres1 = 1'b0; end
          m_diff = W'((ea - eb - en) & MASK);
          m_bor  = (ea < eb + en);
          m_id = exp_g; m_last = exp_g; m_state = 1; m_cnt = 0;
          g_log.push_back(exp_g);
        end
        1: begin
          m_cnt++;
          if (m_cnt == NS) begin m_state = 2; m_done_cnt = 0; end
        end
        default: if (rsp_ready) m_state = 0; else m_done_cnt++;
      endcase
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL traffic_timeout: got pending=%0d want 0", qa0.size() + qa1.size());
    end
    @(negedge clk);
    drive_idle();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (rsp_valid  !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id     !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (rsp_diff   !== '0)   begin n_bad++; $display("FAIL reset_rsp_diff: got %h want 0", rsp_diff); end
    n_cmp++; if (rsp_borrow !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_borrow: got %b want 0", rsp_borrow); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
  endtask

  task automatic test_basic();
    push_req(0, 16'h1234, 16'h0034, 1'b0);
    run_traffic(0, 0, 100);
    push_req(0, 16'h1000, 16'h0001, 1'b0);
    push_req(0, 16'h0000, 16'h0001, 1'b0);
    push_req(0, 16'hABCD, 16'hABCD, 1'b0);
    run_traffic(0, 0, 200);
  endtask

  task automatic test_arbitration();
    do_reset();
    g_log.delete();
    push_req(0, rnd_op(), rnd_op(), 1'b0);
    push_req(1, rnd_op(), rnd_op(), 1'b0);
    push_req(0, rnd_op(), rnd_op(), 1'b0);
    push_req(1, rnd_op(), rnd_op(), 1'b0);
    run_traffic(0, 0, 200);
    n_cmp++;
    if (g_log.size() != 4) begin n_bad++; $display("FAIL grant_count: got %0d want 4", g_log.size()); end
    for (int i = 0; i < 4 && i < g_log.size(); i++) begin
      n_cmp++;
      if (g_log[i] != (i % 2)) begin n_bad++; $display("FAIL grant_order[%0d]: got %0d want %0d", i, g_log[i], i % 2); end
    end
  endtask

  task automatic test_backpressure();
    push_req(0, rnd_op(), rnd_op(), 1'b0);
    push_req(1, rnd_op(), rnd_op(), 1'b0);
    push_req(1, rnd_op(), rnd_op(), 1'b0);
    run_traffic(2, 0, 300);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL mid_hs_ready: got %b want 1", req1_ready); end
    @(negedge clk); drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (rsp_valid  !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id     !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (rsp_diff   !== '0)   begin n_bad++; $display("FAIL mid_rst_rsp_diff: got %h want 0", rsp_diff); end
    n_cmp++; if (rsp_borrow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rsp_borrow: got %b want 0", rsp_borrow); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req0_ready: got %b want 0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req1_ready: got %b want 0", req1_ready); end
    model_reset();
    push_req(1, 16'h8421, 16'h1248, 1'b0);
    run_traffic(0, 0, 100);
    // Pointer must be back at its reset value: a tie now goes to req0 after req1 won last.
    g_log.delete();
    do_reset();
    push_req(0, rnd_op(), rnd_op(), 1'b0);
    push_req(1, rnd_op(), rnd_op(), 1'b0);
    run_traffic(0, 0, 100);
    n_cmp++;
    if (g_log.size() < 1 || g_log[0] != 0) begin n_bad++; $display("FAIL post_reset_first_grant: got %0d want 0", g_log.size() > 0 ? g_log[0] : -1); end
  endtask

  task automatic test_borrow_in();
`ifdef SUB_SLICE_SCHED_BORROW_IN_EN
    push_req(0, 16'h0005, 16'h0005, 1'b1);
    push_req(0, 16'h0005, 16'h0005, 1'b0);
    push_req(1, 16'h0000, 16'hFFFF, 1'b1);
    run_traffic(0, 0, 200);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      push_req(0, rnd_op(), rnd_op(), rnd_bin());
      push_req(1, rnd_op(), rnd_op(), rnd_bin());
    end
    run_traffic(1, 30, 3000);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_basic();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_borrow_in();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
